// File: rtl/distance_relax_store_pkg.sv
// Shared constants and helpers for the Dijkstra node distance store.
// The sizing defaults and FSM encodings are macros so that older blocks that
// only know the macro names keep compiling against the same values.

`ifndef DRS_CONSTANTS_DEFINED
`define DRS_CONSTANTS_DEFINED
`define DEFAULT_MAX_NODES   8
`define DEFAULT_INDEX_WIDTH 3
`define DEFAULT_VALUE_WIDTH 8
`define DRS_IDLE 2'd0
`define DRS_SCAN 2'd1
`define DRS_DONE 2'd2
`endif

package distance_relax_store_pkg;

  // Width of the FSM state register.
  localparam int DRS_STATE_WIDTH = 2;

  // True when a node index addresses a stored entry.
  function automatic logic idx_in_range(input int idx, input int max_nodes);
    return (idx < max_nodes);
  endfunction

endpackage

// File: rtl/distance_relax_store_sat_add.sv
// INFINITY-absorbing saturating adder used for edge relaxation.
// An INFINITY operand or an overflowing sum yields INFINITY (all ones).

module sat_add #(
  parameter int VALUE_WIDTH = 8
) (
  input  logic [VALUE_WIDTH-1:0] a,
  input  logic [VALUE_WIDTH-1:0] b,
  output logic [VALUE_WIDTH-1:0] sum
);

  localparam logic [VALUE_WIDTH-1:0] INFINITY = {VALUE_WIDTH{1'b1}};

  logic [VALUE_WIDTH:0] wide_sum_s;

  // Add with one carry bit, then clamp on overflow or infinite operands.
  always_comb begin
    wide_sum_s = {1'b0, a} + {1'b0, b};
    if ((a == INFINITY) || (b == INFINITY) || wide_sum_s[VALUE_WIDTH]) begin
      sum = INFINITY;
    end else begin
      sum = wide_sum_s[VALUE_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/distance_relax_store.sv
// Node distance store for the Dijkstra datapath: one tentative distance and
// one visited bit per node, single-cycle relaxation, and a sequential scan
// that reports (and optionally marks) the closest unvisited node.

module distance_relax_store
  import distance_relax_store_pkg::*;
#(
  parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
  parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear_en,
  input  logic [INDEX_WIDTH-1:0] clear_src,
  input  logic                   get_en,
  input  logic [INDEX_WIDTH-1:0] get_index,
  output logic [VALUE_WIDTH-1:0] get_value,
  output logic                   get_visited,
  input  logic                   relax_en,
  input  logic [INDEX_WIDTH-1:0] relax_index,
  input  logic [VALUE_WIDTH-1:0] relax_base,
  input  logic [VALUE_WIDTH-1:0] relax_weight,
  output logic                   relax_updated,
  input  logic                   min_start,
  input  logic                   min_mark,
  output logic                   busy,
  output logic                   min_valid,
  output logic                   min_found,
  output logic [INDEX_WIDTH-1:0] min_index,
  output logic [VALUE_WIDTH-1:0] min_value
);

  localparam logic [VALUE_WIDTH-1:0] INFINITY   = {VALUE_WIDTH{1'b1}};
  localparam logic [VALUE_WIDTH-1:0] ZERO_DIST  = {VALUE_WIDTH{1'b0}};
  localparam logic [INDEX_WIDTH-1:0] ZERO_INDEX = {INDEX_WIDTH{1'b0}};
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(MAX_NODES - 1);

  localparam logic [DRS_STATE_WIDTH-1:0] IDLE = `DRS_IDLE;
  localparam logic [DRS_STATE_WIDTH-1:0] SCAN = `DRS_SCAN;
  localparam logic [DRS_STATE_WIDTH-1:0] DONE = `DRS_DONE;

  // Storage
  logic [VALUE_WIDTH-1:0] dist_r [MAX_NODES];
  logic [MAX_NODES-1:0]   visited_r;

  // Control and scan state
  logic [DRS_STATE_WIDTH-1:0] state_r;
  logic [INDEX_WIDTH-1:0]     scan_idx_r;
  logic                       mark_r;
  logic                       best_found_r;
  logic [INDEX_WIDTH-1:0]     best_idx_r;
  logic [VALUE_WIDTH-1:0]     best_val_r;

  // Output registers
  logic [VALUE_WIDTH-1:0] get_value_r;
  logic                   get_visited_r;
  logic                   relax_updated_r;
  logic                   busy_r;
  logic                   min_valid_r;
  logic                   min_found_r;
  logic [INDEX_WIDTH-1:0] min_index_r;
  logic [VALUE_WIDTH-1:0] min_value_r;

  // Combinational helpers
  logic                   idle_s;
  logic                   do_clear_s;
  logic                   do_min_s;
  logic                   do_relax_s;
  logic [VALUE_WIDTH-1:0] relax_cand_s;
  logic                   relax_write_s;
  logic                   mark_now_s;
  logic [VALUE_WIDTH-1:0] scan_dist_s;
  logic                   scan_vis_s;
  logic                   scan_take_s;
  logic                   next_found_s;
  logic [INDEX_WIDTH-1:0] next_idx_s;
  logic [VALUE_WIDTH-1:0] next_val_s;
  logic [VALUE_WIDTH-1:0] get_val_s;
  logic                   get_vis_s;

  sat_add #(
    .VALUE_WIDTH(VALUE_WIDTH)
  ) u_sat_add (
    .a   (relax_base),
    .b   (relax_weight),
    .sum (relax_cand_s)
  );

  // Command arbitration: only IDLE accepts commands, clear beats scan beats relax.
  always_comb begin
    idle_s     = (state_r == IDLE);
    do_clear_s = idle_s && clear_en;
    do_min_s   = idle_s && !clear_en && min_start;
    do_relax_s = idle_s && !clear_en && !min_start && relax_en;
    mark_now_s = (state_r == DONE) && min_found_r && mark_r;
  end

  // Relaxation decision: write only a strictly better distance to an unvisited node.
  always_comb begin
    relax_write_s = 1'b0;
    if (do_relax_s && idx_in_range(32'(relax_index), MAX_NODES)) begin
      relax_write_s = !visited_r[relax_index] && (relax_cand_s < dist_r[relax_index]);
    end else begin
      relax_write_s = 1'b0;
    end
  end

  // Scan step: decide whether the current node becomes the running minimum.
  always_comb begin
    scan_dist_s = INFINITY;
    scan_vis_s  = 1'b1;
    if (idx_in_range(32'(scan_idx_r), MAX_NODES)) begin
      scan_dist_s = dist_r[scan_idx_r];
      scan_vis_s  = visited_r[scan_idx_r];
    end else begin
      scan_dist_s = INFINITY;
      scan_vis_s  = 1'b1;
    end
    scan_take_s = !scan_vis_s && (scan_dist_s != INFINITY) &&
                  (!best_found_r || (scan_dist_s < best_val_r));
    if (scan_take_s) begin
      next_found_s = 1'b1;
      next_idx_s   = scan_idx_r;
      next_val_s   = scan_dist_s;
    end else begin
      next_found_s = best_found_r;
      next_idx_s   = best_idx_r;
      next_val_s   = best_val_r;
    end
  end

  // Read path; forwards the visited mark applied on the DONE edge.
  always_comb begin
    get_val_s = INFINITY;
    get_vis_s = 1'b1;
    if (idx_in_range(32'(get_index), MAX_NODES)) begin
      get_val_s = dist_r[get_index];
      get_vis_s = visited_r[get_index] || (mark_now_s && (get_index == min_index_r));
    end else begin
      get_val_s = INFINITY;
      get_vis_s = 1'b1;
    end
  end

  // Distance and visited storage: reset/clear, relaxation writes, scan marking.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MAX_NODES; i++) begin
        dist_r[i] <= INFINITY;
      end
      visited_r <= '0;
    end else if (do_clear_s) begin
      for (int i = 0; i < MAX_NODES; i++) begin
        dist_r[i] <= (INDEX_WIDTH'(i) == clear_src) ? ZERO_DIST : INFINITY;
      end
      visited_r <= '0;
    end else if (relax_write_s) begin
      dist_r[relax_index] <= relax_cand_s;
    end else if (mark_now_s) begin
      visited_r[min_index_r] <= 1'b1;
    end
  end

  // Scan FSM: walks every node once, then publishes the result for one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      scan_idx_r   <= ZERO_INDEX;
      mark_r       <= 1'b0;
      best_found_r <= 1'b0;
      best_idx_r   <= ZERO_INDEX;
      best_val_r   <= INFINITY;
      busy_r       <= 1'b0;
      min_valid_r  <= 1'b0;
      min_found_r  <= 1'b0;
      min_index_r  <= ZERO_INDEX;
      min_value_r  <= ZERO_DIST;
    end else begin
      min_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (do_min_s) begin
            state_r      <= SCAN;
            busy_r       <= 1'b1;
            scan_idx_r   <= ZERO_INDEX;
            mark_r       <= min_mark;
            best_found_r <= 1'b0;
            best_idx_r   <= ZERO_INDEX;
            best_val_r   <= INFINITY;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        SCAN: begin
          if (scan_idx_r == LAST_INDEX) begin
            state_r     <= DONE;
            min_valid_r <= 1'b1;
            min_found_r <= next_found_s;
            min_index_r <= next_found_s ? next_idx_s : ZERO_INDEX;
            min_value_r <= next_found_s ? next_val_s : INFINITY;
          end else begin
            scan_idx_r   <= scan_idx_r + 1'b1;
            best_found_r <= next_found_s;
            best_idx_r   <= next_idx_s;
            best_val_r   <= next_val_s;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Get and relax response registers; get outputs hold while get_en is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      get_value_r     <= INFINITY;
      get_visited_r   <= 1'b0;
      relax_updated_r <= 1'b0;
    end else begin
      relax_updated_r <= relax_write_s;
      if (get_en) begin
        get_value_r   <= get_val_s;
        get_visited_r <= get_vis_s;
      end
    end
  end

  assign get_value     = get_value_r;
  assign get_visited   = get_visited_r;
  assign relax_updated = relax_updated_r;
  assign busy          = busy_r;
  assign min_valid     = min_valid_r;
  assign min_found     = min_found_r;
  assign min_index     = min_index_r;
  assign min_value     = min_value_r;

endmodule

// File: doc/distance_relax_store.md
# distance_relax_store

Parametrised successor to the node distance store for the Dijkstra datapath. It holds one tentative distance and one visited bit per node. It performs the edge-relaxation compare-and-update (saturating add plus conditional write) in one cycle, and runs a sequential scan that returns the minimum-distance unvisited node. It sits between the graph-edge fetch logic and the top-level Dijkstra controller, replacing separate get/set traffic with relax and find-min commands.

## Interface
- MAX_NODES, `DEFAULT_MAX_NODES, number of nodes stored (≥2)
- INDEX_WIDTH, `DEFAULT_INDEX_WIDTH, node index width; 2**INDEX_WIDTH ≥ MAX_NODES
- VALUE_WIDTH, `DEFAULT_VALUE_WIDTH, distance width; all-ones encodes INFINITY
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- clear_en  in  1  reinitialise store with source node
- clear_src  in  INDEX_WIDTH  source node (distance 0)
- get_en  in  1  read request
- get_index  in  INDEX_WIDTH  node to read
- get_value  out  VALUE_WIDTH  registered distance
- get_visited  out  1  registered visited bit
- relax_en  in  1  relaxation request
- relax_index  in  INDEX_WIDTH  destination node
- relax_base  in  VALUE_WIDTH  distance of the source node
- relax_weight  in  VALUE_WIDTH  edge weight
- relax_updated  out  1  one-cycle pulse: write took place
- min_start  in  1  start minimum scan
- min_mark  in  1  sampled with min_start; mark result visited
- busy  out  1  scan in progress
- min_valid  out  1  one-cycle result strobe
- min_found  out  1  a finite unvisited node exists
- min_index  out  INDEX_WIDTH  result node
- min_value  out  VALUE_WIDTH  result distance

## Operation
- Reset: every dist = INFINITY, every visited = 0, state IDLE. All outputs are 0 except get_value = INFINITY.
- clear_en (IDLE only): dist[clear_src] = 0, all other dist = INFINITY, all visited = 0. Takes effect in one cycle.
- get_en: get_value and get_visited reflect the entry on the next cycle. Accepted in any state. Outputs hold their value when get_en is low.
- relax_en (IDLE only):
  - candidate = relax_base + relax_weight, saturated to INFINITY.
  - relax_base == INFINITY gives INFINITY.
  - The write occurs iff visited[relax_index] == 0 and candidate < dist[relax_index] (strict).
  - relax_updated pulses on the next cycle iff the write occurred.
- Priority in IDLE: clear_en > min_start > relax_en. A lower-priority request in the same cycle is dropped, not queued.
- While busy: clear_en, relax_en and min_start are ignored. get_en is still served.
- Out-of-range index (≥ MAX_NODES): get returns INFINITY/visited=1, relax is a no-op, clear leaves all entries INFINITY.
- FSM:
  - IDLE → SCAN on min_start. Latches min_mark and resets the running min.
  - SCAN visits index 0..MAX_NODES-1, one per cycle. A candidate qualifies iff it is unvisited and its distance is not INFINITY. Strict < keeps the lowest index on ties.
  - After the last index, SCAN → DONE.
  - DONE: min_valid = 1 for one cycle, then back to IDLE.
  - If nothing qualified: min_found = 0, min_index = 0, min_value = INFINITY.
  - If min_found and the latched mark is set: visited[min_index] is set on the DONE edge.
- reset during SCAN/DONE: immediate return to IDLE. No min_valid, no visited update.

## Timing
- get, relax: 1-cycle latency.
- min_start sampled at edge 0 → busy high from cycle 1 through cycle MAX_NODES+1. min_valid is high in cycle MAX_NODES+1.
- min_* outputs hold their value until the next DONE or reset.
- A get_en in the min_valid cycle sees the visited bit updated by that DONE on the following cycle.
- A new min_start is accepted in the cycle after min_valid.

## Structure
- constants.v (shared, `include'd): `DEFAULT_MAX_NODES, `DEFAULT_INDEX_WIDTH, `DEFAULT_VALUE_WIDTH. Add FSM state encodings `DRS_IDLE/`DRS_SCAN/`DRS_DONE.
- INFINITY is derived locally as {VALUE_WIDTH{1'b1}}.
- One sub-module: sat_add (VALUE_WIDTH parameter; INFINITY-absorbing saturating adder).
- Storage is flops (dist array plus visited vector), so clear completes in one cycle.

## Test plan
All scenarios use MAX_NODES=8, VALUE_WIDTH=8.
- Reset, then get_en for each index 0..7 → get_value=8'hFF, get_visited=0 for every index.
- clear_src=2; relax idx5 base0 weight7 → dist[5]=7, relax_updated=1. Relax idx5 base3 weight4 (=7, not less) → no write, relax_updated=0.
- Relax idx4 base 8'hF0 weight 8'h20 → candidate saturates to FF, no write. Relax with base FF weight 1 → no write.
- After clear_src=2 and dist[5]=7: min_start with min_mark=1 → busy for 9 cycles, min_valid in cycle 9 with min_index=2, min_value=0, min_found=1. Then get idx2 → visited=1.
- Tie: dist[3]=dist[6]=4 with 2 visited → scan returns min_index=3. Mark all nodes visited → min_found=0, min_value=FF. Relax to a visited node → no write.
- Assert reset at scan cycle 4 → busy=0 next cycle, no min_valid, visited bits unchanged. A relax_en during busy is ignored.
